// File: rtl/ov5640_dvp_capture_pkg.sv
// Shared types and constants for the OV5640 DVP capture path.
// RGB565 field positions are shared with the output formatter.
package ov5640_dvp_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SKIP  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int CNT_W = 12;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Sensor order {R,G,B} to frame-buffer order {B,G,R}
    function automatic logic [15:0] rgb_to_bgr(input logic [15:0] p);
        return {p[B_MSB:B_LSB], p[G_MSB:G_LSB], p[R_MSB:R_LSB]};
    endfunction

endpackage

// File: rtl/dvp_byte_pairer.sv
// Pairs DVP bytes into 16-bit pixels; first byte of a pair is the high byte.
// The pixel is valid combinationally on the second byte; the top registers it.
module dvp_byte_pairer
    import ov5640_dvp_capture_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    input  logic        i_clr,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic [15:0] o_pixel,
    output logic        o_valid,
    output logic        o_odd
);

    logic       r_phase;
    logic [7:0] r_hi;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= 1'b0;
            r_hi    <= 8'd0;
        end else if (!i_run || i_clr || !i_href) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase)
                r_hi <= i_data;
        end
    end

    assign o_valid = i_run & ~i_clr & i_href & r_phase;
    assign o_pixel = {r_hi, i_data};
    assign o_odd   = r_phase;

endmodule

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP RGB565 capture: frame skip, crop, geometry checks,
// and vs_n/de/data output toward the frame buffer write port.
module ov5640_dvp_capture
    import ov5640_dvp_capture_pkg::*;
#(
    parameter int H_RES       = 1024,
    parameter int V_RES       = 768,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst,
    input  logic        I_enable,
    input  logic        I_err_clr,
    input  logic        I_cam_vsync,
    input  logic        I_cam_href,
    input  logic [7:0]  I_cam_data,
    output logic        O_vs_n,
    output logic        O_de,
    output logic [15:0] O_data,
    output logic        O_active,
    output logic [7:0]  O_frame_cnt,
    output logic        O_line_err,
    output logic        O_frame_err
);

    localparam logic [CNT_W-1:0] W_H   = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] W_V   = CNT_W'(V_RES);
    localparam logic [CNT_W-1:0] W_MAX = '1;
    localparam logic [CNT_W-1:0] W_ONE = CNT_W'(1);
    localparam logic [7:0]       W_SKL = 8'(SKIP_FRAMES - 1);

    state_t           r_state;
    logic             r_vs1, r_vs1_q, r_hr1, r_hr1_q;
    logic [7:0]       r_d1;
    logic [7:0]       r_skip;
    logic [CNT_W-1:0] r_pix, r_line;
    logic             r_vs_n, r_de, r_active, r_line_err, r_frame_err;
    logic [15:0]      r_data;
    logic [7:0]       r_frame_cnt;

    logic        w_run, w_vs_rise, w_vs_edge, w_href_fall;
    logic        w_valid, w_odd, w_line_set, w_frame_set;
    logic [15:0] w_pixel;

    assign w_run       = (r_state == ST_RUN);
    assign w_vs_rise   = r_vs1 & ~r_vs1_q;
    assign w_vs_edge   = r_vs1 ^ r_vs1_q;
    assign w_href_fall = r_hr1_q & ~r_hr1;
    assign w_line_set  = w_run & w_href_fall & ((r_pix != W_H) | w_odd);
    assign w_frame_set = w_run & w_vs_rise & (r_line != W_V);

    dvp_byte_pairer u_pairer (
        .i_clk   (I_pxl_clk),
        .i_rst   (I_rst),
        .i_run   (w_run),
        .i_clr   (w_vs_edge),
        .i_href  (r_hr1),
        .i_data  (r_d1),
        .o_pixel (w_pixel),
        .o_valid (w_valid),
        .o_odd   (w_odd)
    );

    // S1 vsync resets high so a sensor already in blank gives no false edge
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            r_vs1   <= 1'b1;
            r_vs1_q <= 1'b1;
            r_hr1   <= 1'b0;
            r_hr1_q <= 1'b0;
            r_d1    <= 8'd0;
        end else begin
            r_vs1   <= I_cam_vsync;
            r_vs1_q <= r_vs1;
            r_hr1   <= I_cam_href;
            r_hr1_q <= r_hr1;
            r_d1    <= I_cam_data;
        end
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            r_state     <= ST_IDLE;
            r_skip      <= 8'd0;
            r_pix       <= '0;
            r_line      <= '0;
            r_vs_n      <= 1'b1;
            r_de        <= 1'b0;
            r_data      <= 16'd0;
            r_active    <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_de   <= 1'b0;
            r_vs_n <= 1'b1;

            if (w_line_set)
                r_line_err <= 1'b1;
            else if (I_err_clr)
                r_line_err <= 1'b0;

            if (w_frame_set)
                r_frame_err <= 1'b1;
            else if (I_err_clr)
                r_frame_err <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    r_pix  <= '0;
                    r_line <= '0;
                    r_skip <= 8'd0;
                    if (I_enable)
                        r_state <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (!I_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_vs_rise) begin
                        r_skip <= 8'd0;
                        if (SKIP_FRAMES == 0) begin
                            r_state  <= ST_RUN;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= ST_SKIP;
                        end
                    end
                end
                ST_SKIP: begin
                    if (!I_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_vs_rise) begin
                        if (r_skip == W_SKL) begin
                            r_state  <= ST_RUN;
                            r_active <= 1'b1;
                        end else begin
                            r_skip <= r_skip + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    r_vs_n <= ~r_vs1;
                    if (w_valid) begin
                        if (r_pix < W_H && r_line < W_V) begin
                            r_de   <= 1'b1;
                            r_data <= rgb_to_bgr(w_pixel);
                        end
                        if (r_pix != W_MAX)
                            r_pix <= r_pix + W_ONE;
                    end
                    if (w_href_fall) begin
                        r_pix <= '0;
                        if (r_line != W_MAX)
                            r_line <= r_line + W_ONE;
                    end
                    // Enable is only honoured at frame end
                    if (w_vs_rise) begin
                        r_line      <= '0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        if (!I_enable) begin
                            r_state  <= ST_IDLE;
                            r_active <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign O_vs_n      = r_vs_n;
    assign O_de        = r_de;
    assign O_data      = r_data;
    assign O_active    = r_active;
    assign O_frame_cnt = r_frame_cnt;
    assign O_line_err  = r_line_err;
    assign O_frame_err = r_frame_err;

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Bench for ov5640_dvp_capture: random DVP frames vs a pixel-list model,
// using a reduced 16x8 geometry with two skipped frames.
module tb_ov5640_dvp_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        rst, en, clr, vs, hr;
    logic [7:0]  d;
    logic        o_vs_n, o_de, o_active, o_line_err, o_frame_err;
    logic [15:0] o_data;
    logic [7:0]  o_frame_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int de_total = 0;
    int vsn_low  = 0;

    logic [15:0] exp_q[$];
    logic [15:0] cap_q[$];
    int          pix_cyc[$];
    int          cap_cyc[$];
    logic [7:0]  force_q[$];

    ov5640_dvp_capture #(.H_RES(H), .V_RES(V), .SKIP_FRAMES(SK)) dut (
        .I_pxl_clk   (clk),
        .I_rst       (rst),
        .I_enable    (en),
        .I_err_clr   (clr),
        .I_cam_vsync (vs),
        .I_cam_href  (hr),
        .I_cam_data  (d),
        .O_vs_n      (o_vs_n),
        .O_de        (o_de),
        .O_data      (o_data),
        .O_active    (o_active),
        .O_frame_cnt (o_frame_cnt),
        .O_line_err  (o_line_err),
        .O_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_de) begin
            cap_q.push_back(o_data);
            cap_cyc.push_back(cyc);
            de_total++;
        end
        if (!o_vs_n)
            vsn_low++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] remap(input logic [15:0] p);
        int r, g, b;
        r = int'(p) / 2048;
        g = (int'(p) / 32) % 64;
        b = int'(p) % 32;
        return 16'(b * 2048 + g * 32 + r);
    endfunction

    // -2: pixel count differs; i: first bad value or latency; -1: all match
    function automatic int first_diff(input int c0);
        if (cap_q.size() - c0 != exp_q.size())
            return -2;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (cap_q[c0+i] !== exp_q[i])
                return i;
            if (cap_cyc[c0+i] - pix_cyc[i] != 2)
                return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int nbytes, input int lidx, input bit fwd);
        logic [7:0]  hi, b;
        logic [15:0] p;
        hi = 8'd0;
        for (int k = 0; k < nbytes; k++) begin
            tick();
            if (force_q.size() > 0)
                b = force_q.pop_front();
            else
                b = 8'($urandom_range(0, 255));
            hr = 1'b1;
            d  = b;
            if (k % 2 == 0) begin
                hi = b;
            end else if (fwd && lidx < V && k / 2 < H) begin
                p = {hi, b};
                exp_q.push_back(remap(p));
                pix_cyc.push_back(cyc);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            hr = 1'b0;
            d  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic frame_begin();
        tick();
        vs = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_end();
        tick();
        vs = 1'b1;
        repeat (8) tick();
    endtask

    task automatic send_frame(input int nl, input int nb, input bit fwd);
        frame_begin();
        for (int l = 0; l < nl; l++)
            send_line(nb, l, fwd);
        frame_end();
    endtask

    task automatic err_pulse();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        vs = 1'b1; hr = 1'b0; d = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (o_vs_n !== 1'b1) begin errors++; $display("FAIL rst_vs_n: got %b need 1", o_vs_n); end
        checks++; if (o_de !== 1'b0) begin errors++; $display("FAIL rst_de: got %b need 0", o_de); end
        checks++; if (o_data !== 16'd0) begin errors++; $display("FAIL rst_data: got %h need 0000", o_data); end
        checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b need 0", o_active); end
        checks++; if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_fcnt: got %0d need 0", o_frame_cnt); end
        checks++; if ({o_line_err, o_frame_err} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b need 00", {o_line_err, o_frame_err}); end
    endtask

    task automatic test_idle();
        int d0, v0;
        d0 = de_total;
        v0 = vsn_low;
        repeat (3) send_frame(V, 2 * H, 1'b0);
        checks++; if (de_total != d0) begin errors++; $display("FAIL idle_de: got %0d pulses need 0", de_total - d0); end
        checks++; if (vsn_low != v0) begin errors++; $display("FAIL idle_vs_n: got %0d low cycles need 0", vsn_low - v0); end
        checks++; if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL idle_fcnt: got %0d need 0", o_frame_cnt); end
        checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL idle_active: got %b need 0", o_active); end
    endtask

    task automatic test_skip();
        int c0, n;
        exp_q.delete(); pix_cyc.delete();
        c0 = cap_q.size();
        frame_begin();
        for (int l = 0; l < 3; l++) send_line(2 * H, l, 1'b0);
        en = 1'b1;
        for (int l = 3; l < V; l++) send_line(2 * H, l, 1'b0);
        frame_end();
        send_frame(V, 2 * H, 1'b0);
        checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL skip_early: active got %b need 0", o_active); end
        send_frame(V, 2 * H, 1'b0);
        checks++; if (o_active !== 1'b1) begin errors++; $display("FAIL skip_run: active got %b need 1", o_active); end
        send_frame(V, 2 * H, 1'b1);
        n = first_diff(c0);
        checks++; if (n != -1) begin errors++; $display("FAIL skip_stream: diff at %0d got %0d px need %0d", n, cap_q.size() - c0, exp_q.size()); end
        checks++; if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL skip_fcnt: got %0d need 1", o_frame_cnt); end
        checks++; if ({o_line_err, o_frame_err} !== 2'b00) begin errors++; $display("FAIL skip_err: got %b need 00", {o_line_err, o_frame_err}); end
    endtask

    task automatic test_format();
        int c0, n;
        exp_q.delete(); pix_cyc.delete();
        force_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
        c0 = cap_q.size();
        send_frame(V, 2 * H, 1'b1);
        n = first_diff(c0);
        checks++; if (n != -1) begin errors++; $display("FAIL fmt_stream: diff at %0d got %0d px need %0d", n, cap_q.size() - c0, exp_q.size()); end
        checks++; if (cap_q[c0] !== 16'hF81F) begin errors++; $display("FAIL fmt_px0: got %h need f81f", cap_q[c0]); end
        checks++; if (cap_q[c0+1] !== 16'h07E0) begin errors++; $display("FAIL fmt_px1: got %h need 07e0", cap_q[c0+1]); end
        checks++; if (cap_cyc[c0+1] - pix_cyc[1] != 2) begin errors++; $display("FAIL fmt_latency: got %0d need 2", cap_cyc[c0+1] - pix_cyc[1]); end
        checks++; if (o_vs_n !== 1'b0) begin errors++; $display("FAIL fmt_vs_n_blank: got %b need 0", o_vs_n); end
        checks++; if (o_frame_cnt !== 8'd2) begin errors++; $display("FAIL fmt_fcnt: got %0d need 2", o_frame_cnt); end
    endtask

    task automatic test_short_odd();
        int c0, n;
        exp_q.delete(); pix_cyc.delete();
        c0 = cap_q.size();
        frame_begin();
        send_line(2 * H - 2, 0, 1'b1);
        checks++; if (o_line_err !== 1'b1) begin errors++; $display("FAIL short_set: got %b need 1", o_line_err); end
        err_pulse();
        checks++; if (o_line_err !== 1'b0) begin errors++; $display("FAIL short_clr: got %b need 0", o_line_err); end
        send_line(2 * H - 1, 1, 1'b1);
        checks++; if (o_line_err !== 1'b1) begin errors++; $display("FAIL odd_set: got %b need 1", o_line_err); end
        for (int l = 2; l < V; l++) send_line(2 * H, l, 1'b1);
        frame_end();
        n = first_diff(c0);
        checks++; if (n != -1) begin errors++; $display("FAIL short_stream: diff at %0d got %0d px need %0d", n, cap_q.size() - c0, exp_q.size()); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL short_ferr: got %b need 0", o_frame_err); end
        err_pulse();
        checks++; if (o_line_err !== 1'b0) begin errors++; $display("FAIL odd_clr: got %b need 0", o_line_err); end
        checks++; if (o_frame_cnt !== 8'd3) begin errors++; $display("FAIL short_fcnt: got %0d need 3", o_frame_cnt); end
    endtask

    task automatic test_oversize();
        int c0, n;
        exp_q.delete(); pix_cyc.delete();
        c0 = cap_q.size();
        send_frame(V + 2, 2 * (H + 6), 1'b1);
        n = first_diff(c0);
        checks++; if (n != -1) begin errors++; $display("FAIL over_stream: diff at %0d got %0d px need %0d", n, cap_q.size() - c0, exp_q.size()); end
        checks++; if (o_frame_err !== 1'b1) begin errors++; $display("FAIL over_ferr: got %b need 1", o_frame_err); end
        checks++; if (o_line_err !== 1'b1) begin errors++; $display("FAIL over_lerr: got %b need 1", o_line_err); end
        err_pulse();
        checks++; if ({o_line_err, o_frame_err} !== 2'b00) begin errors++; $display("FAIL over_clr: got %b need 00", {o_line_err, o_frame_err}); end
    endtask

    task automatic test_enable_drop();
        int c0, n, d0;
        exp_q.delete(); pix_cyc.delete();
        c0 = cap_q.size();
        frame_begin();
        for (int l = 0; l < V / 2; l++) send_line(2 * H, l, 1'b1);
        en = 1'b0;
        for (int l = V / 2; l < V; l++) send_line(2 * H, l, 1'b1);
        frame_end();
        n = first_diff(c0);
        checks++; if (n != -1) begin errors++; $display("FAIL drop_stream: diff at %0d got %0d px need %0d", n, cap_q.size() - c0, exp_q.size()); end
        checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL drop_active: got %b need 0", o_active); end
        checks++; if (o_frame_cnt !== 8'd5) begin errors++; $display("FAIL drop_fcnt: got %0d need 5", o_frame_cnt); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL drop_ferr: got %b need 0", o_frame_err); end
        d0 = de_total;
        send_frame(V, 2 * H, 1'b0);
        checks++; if (de_total != d0) begin errors++; $display("FAIL drop_after: got %0d pulses need 0", de_total - d0); end
    endtask

    task automatic test_reset_mid();
        int c0, n;
        en = 1'b1;
        repeat (1 + SK) send_frame(V, 2 * H, 1'b0);
        frame_begin();
        for (int l = 0; l < V / 2; l++) send_line(2 * H, l, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({o_vs_n, o_de, o_active} !== 3'b100) begin errors++; $display("FAIL rmid_ctl: got %b need 100", {o_vs_n, o_de, o_active}); end
        checks++; if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL rmid_fcnt: got %0d need 0", o_frame_cnt); end
        checks++; if (o_data !== 16'd0) begin errors++; $display("FAIL rmid_data: got %h need 0000", o_data); end
        exp_q.delete(); pix_cyc.delete();
        c0 = cap_q.size();
        for (int l = V / 2; l < V; l++) send_line(2 * H, l, 1'b0);
        frame_end();
        send_frame(V, 2 * H, 1'b0);
        checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL rmid_skip: active got %b need 0", o_active); end
        send_frame(V, 2 * H, 1'b0);
        send_frame(V, 2 * H, 1'b1);
        n = first_diff(c0);
        checks++; if (n != -1) begin errors++; $display("FAIL rmid_stream: diff at %0d got %0d px need %0d", n, cap_q.size() - c0, exp_q.size()); end
        checks++; if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL rmid_fcnt_after: got %0d need 1", o_frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_skip();
        test_format();
        test_short_odd();
        test_oversize();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ov5640_dvp_capture.md
Name: ov5640_dvp_capture

Overview:
Camera-side capture stage that sits directly upstream of the frame buffer's vin0 write port. It receives the OV5640 DVP byte stream (PCLK, VSYNC, HREF, D[7:0]) in RGB565 mode and pairs bytes into 16-bit pixels. It drops the sensor's start-up frames, crops to the configured resolution, and emits vs_n/de/data in the 16-bit video format the frame buffer consumes. It also reports a frame counter and sticky geometry-error flags for board LEDs and debug.

Parameters:
H_RES, 1024, active pixels per line forwarded (max 4095)
V_RES, 768, active lines per frame forwarded (max 4095)
SKIP_FRAMES, 10, complete frames discarded after enable before forwarding (0..255)

Ports:
I_pxl_clk  in  1  camera PCLK; sole clock, all logic on rising edge
I_rst  in  1  synchronous reset, active-high
I_enable  in  1  capture enable; driven by the sensor-config-done flag
I_err_clr  in  1  single-cycle pulse; clears sticky error flags
I_cam_vsync  in  1  sensor VSYNC, active-high (high = vertical blank)
I_cam_href  in  1  sensor HREF, active-high during valid line bytes
I_cam_data  in  8  sensor D[7:0]
O_vs_n  out  1  frame sync to frame buffer, active-low
O_de  out  1  pixel valid, one cycle per pixel
O_data  out  16  pixel {B[4:0],G[5:0],R[4:0]} (R in bits 4:0)
O_active  out  1  high while in RUN state
O_frame_cnt  out  8  count of frames forwarded, wraps 255->0
O_line_err  out  1  sticky: some forwarded line had length != H_RES or an odd byte count
O_frame_err  out  1  sticky: some forwarded frame had line count != V_RES

Behaviour:
- Input stage: vsync, href and data are registered once (stage S1). All decisions use S1 values. vsync edges are detected from S1 and the previous S1 value.
- Reset values: O_vs_n=1, O_de=0, O_data=0, O_active=0, O_frame_cnt=0, both error flags 0. FSM is in IDLE, byte phase 0, all counters 0.
- FSM states: IDLE, ALIGN, SKIP, RUN.
  - IDLE -> ALIGN when I_enable=1.
  - ALIGN -> SKIP on vsync rising edge. If SKIP_FRAMES=0, go directly to RUN.
  - SKIP counts vsync rising edges. It goes to RUN on the edge that completes SKIP_FRAMES frames.
  - RUN -> IDLE on a vsync rising edge when I_enable=0. Deasserting enable mid-frame therefore never truncates a frame.
  - Any state other than RUN -> IDLE immediately when I_enable=0.
- Outside RUN: O_vs_n=1 and O_de=0. Byte phase and counters are held at 0.
- In RUN: O_vs_n = ~S1 vsync, registered, so it is aligned with O_de.
- Byte pairing: while S1 href=1, bytes alternate phase 0 and phase 1.
  - Phase 0 byte is latched as the high byte.
  - Phase 1 completes the pixel P = {hi,lo}, where P[15:11]=R, P[10:5]=G, P[4:0]=B.
  - Output remap is O_data = {P[4:0],P[10:5],P[15:11]}.
- Latency: O_de/O_data are asserted exactly 2 clocks after the second byte of the pixel appears on I_cam_data. The minimum pixel spacing is 2 clocks.
- The byte phase resets to 0 on every href falling edge and every vsync edge.
- Crop: a pixel is forwarded only if pix_cnt < H_RES and line_cnt < V_RES. Excess pixels and lines are silently dropped.
- End-of-line check (href falling edge in RUN): set O_line_err if pix_cnt != H_RES or the byte phase was 1. A leftover odd byte is discarded. pix_cnt is then cleared and line_cnt incremented (saturating at 4095).
- End-of-frame (vsync rising edge in RUN):
  - Set O_frame_err if line_cnt != V_RES.
  - O_frame_cnt increments, including the final frame before leaving RUN.
  - line_cnt is cleared.
- I_err_clr clears both flags. If it coincides with a new error in the same cycle, the set wins.
- Reset asserted mid-frame: everything returns to reset values on the next edge. After release, a full ALIGN/SKIP sequence is required again.
- The frame counter wraps modulo 256 with no flag.

Decomposition:
- Shared package: FSM state encoding (IDLE/ALIGN/SKIP/RUN, 2 bits), counter width constant CNT_W=12, and the RGB565 field-position constants used by both this block and the output formatter.
- One sub-module: dvp_byte_pairer. It takes S1 href/data and produces pixel + valid + odd_byte flag, and keeps the FSM/counter logic separate from byte assembly.

Test Plan:
- Reset/idle: I_enable=0, the sensor streams 3 frames of 1024x768 -> O_de never 1, O_vs_n stays 1, O_frame_cnt=0, O_active=0.
- Skip and alignment: SKIP_FRAMES=2, enable asserted mid-frame -> the partial frame plus 2 full frames are dropped. The 3rd full frame is forwarded with exactly 1024 O_de per line for 768 lines. O_frame_cnt=1 after it.
- Pixel format and latency: bytes 0xF8,0x1F (R=31,G=0,B=31) then 0x07,0xE0 (G=63) -> O_data=0xF81F then 0x07E0. Each O_de occurs 2 clocks after its second byte.
- Short/odd line: one line of 1023 pixels, then a line with 2047 bytes -> O_line_err=1 after the first. 1023 O_de on the first line and 1023 on the second; the odd byte is dropped. I_err_clr -> flag 0.
- Oversize frame: 1030 pixels x 770 lines -> per frame exactly 1024x768 O_de pulses. O_frame_err=1, O_line_err=1.
- Enable drop and reset: I_enable deasserted at line 300 -> the frame completes to 768 lines, then O_active=0. A separate run with I_rst pulsed at line 300 -> outputs at reset values the next cycle, and the full skip sequence is required again.
